// File: rtl/mem_refill_ctrl_pkg.sv
// Shared types and constants for the main-memory refill controller.
package mem_refill_pkg;
  localparam int unsigned MEM_WORDS = 16;
  localparam int unsigned DATA_W    = 3;
  localparam int unsigned ADDR_W    = 4;

  typedef enum logic [1:0] {IDLE, WB, RD, FIN} state_t;

  // Power-on / reset contents: each word holds the low bits of its own address.
  function automatic logic [DATA_W-1:0] init_word(input int unsigned i);
    return DATA_W'(i);
  endfunction
endpackage

// File: rtl/mem_refill_ctrl_if.sv
// Cache <-> refill controller request/response bundle.
interface mem_refill_ctrl_if;
  import mem_refill_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wb;
  logic              req_refill;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] refill_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              done;
  logic              busy;

  modport master (
    output req_valid, req_wb, req_refill, wb_addr, wb_data, refill_addr,
    input  req_ready, resp_valid, resp_data, done, busy
  );

  modport slave (
    input  req_valid, req_wb, req_refill, wb_addr, wb_data, refill_addr,
    output req_ready, resp_valid, resp_data, done, busy
  );
endinterface

// File: rtl/mem_refill_ctrl_mem_array.sv
// 16x3 main-memory storage: synchronous write, combinational read, reset re-initialises contents.
module mem_array_16x3
  import mem_refill_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) r_mem[i] <= init_word(i);
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mem_refill_ctrl.sv
// Miss-service sequencer: optional victim write-back, then optional refill read, each LATENCY cycles.
// Define MEM_REFILL_STATS_EN to add saturating refill / write-back commit counters.
module mem_refill_ctrl
  import mem_refill_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic       clock,
  input  logic       reset,
  mem_refill_ctrl_if.slave bus
`ifdef MEM_REFILL_STATS_EN
  ,
  output logic [7:0] stat_refills,
  output logic [7:0] stat_writebacks
`endif
);
  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_ready, r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_refill;
  logic [ADDR_W-1:0] r_wb_addr, r_refill_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic [DATA_W-1:0] w_rdata;
  logic              w_accept, w_last, w_wr_commit, w_rd_commit, w_done, w_busy;

  assign w_accept = bus.req_valid && r_ready;
  assign w_last   = (r_cnt == 4'(LATENCY - 1));

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (bus.req_wb)          w_next = WB;
        else if (bus.req_refill) w_next = RD;
        else                     w_next = FIN;
      end
      WB:   if (w_last) w_next = r_refill ? RD : FIN;
      RD:   if (w_last) w_next = FIN;
      FIN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_done      = (r_state == FIN);
    w_busy      = (r_state != IDLE);
    w_wr_commit = (r_state == WB) && w_last;
    w_rd_commit = (r_state == RD) && w_last;
  end

  // Counter restarts on every state change so each access phase counts from zero.
  always_ff @(posedge clock) begin
    if (reset)                                    r_cnt <= '0;
    else if (w_next != r_state)                   r_cnt <= '0;
    else if (r_state == WB || r_state == RD)      r_cnt <= r_cnt + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ready       <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_refill      <= 1'b0;
      r_wb_addr     <= '0;
      r_wb_data     <= '0;
      r_refill_addr <= '0;
    end else begin
      r_ready      <= (w_next == IDLE);
      r_resp_valid <= w_rd_commit;
      if (w_rd_commit) r_resp_data <= w_rdata;
      if (w_accept) begin
        r_refill      <= bus.req_refill;
        r_wb_addr     <= bus.wb_addr;
        r_wb_data     <= bus.wb_data;
        r_refill_addr <= bus.refill_addr;
      end
    end
  end

  mem_array_16x3 u_mem (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_we    (w_wr_commit),
    .i_waddr (r_wb_addr),
    .i_wdata (r_wb_data),
    .i_raddr (r_refill_addr),
    .o_rdata (w_rdata)
  );

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.done       = w_done;
  assign bus.busy       = w_busy;

`ifdef MEM_REFILL_STATS_EN
  logic [7:0] r_stat_rf, r_stat_wb;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_rf <= '0;
      r_stat_wb <= '0;
    end else begin
      if (w_rd_commit && r_stat_rf != '1) r_stat_rf <= r_stat_rf + 8'd1;
      if (w_wr_commit && r_stat_wb != '1) r_stat_wb <= r_stat_wb + 8'd1;
    end
  end

  assign stat_refills    = r_stat_rf;
  assign stat_writebacks = r_stat_wb;
`endif
endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Self-checking bench for mem_refill_ctrl: transaction-level model plus directed literal checks.
module tb_mem_refill_ctrl;
  localparam int unsigned L = 2;

  logic clk;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  mem_refill_ctrl_if bus ();

`ifdef MEM_REFILL_STATS_EN
  logic [7:0] stat_refills, stat_writebacks;
`endif

  mem_refill_ctrl #(.LATENCY(L)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef MEM_REFILL_STATS_EN
    ,
    .stat_refills    (stat_refills),
    .stat_writebacks (stat_writebacks)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
  endtask

  // Transaction model: a request is a countdown of (wb?L:0)+(refill?L:0)+1 cycles,
  // memory effects applied at accept in program order.
  logic       m_init = 1'b0;
  int         m_k    = 0;
  int         m_D    = 0;
  logic       m_rf   = 1'b0;
  logic [2:0] m_pend = '0;
  logic [2:0] m_resp = '0;
  logic [2:0] m_mem [16];

  always @(negedge clk) begin
    logic e_busy, e_done, e_rv;
    if (m_init) begin
      e_busy = (m_k != 0);
      e_done = e_busy && (m_k == m_D);
      e_rv   = e_done && m_rf;
      chk("m_ready", bus.req_ready, !e_busy);
      chk("m_busy", bus.busy, e_busy);
      chk("m_done", bus.done, e_done);
      chk("m_resp_valid", bus.resp_valid, e_rv);
      chk("m_resp_data", bus.resp_data, m_resp);
    end
    if (reset) begin
      m_init = 1'b1;
      m_k    = 0;
      m_resp = '0;
      for (int i = 0; i < 16; i++) m_mem[i] = 3'(i);
    end else if (m_init) begin
      if (m_k != 0) begin
        if (m_k == m_D) m_k = 0;
        else m_k++;
      end else if (bus.req_valid) begin
        m_D  = (bus.req_wb ? int'(L) : 0) + (bus.req_refill ? int'(L) : 0) + 1;
        m_rf = bus.req_refill;
        if (bus.req_wb) m_mem[bus.wb_addr] = bus.wb_data;
        m_pend = m_mem[bus.refill_addr];
        m_k = 1;
      end
      if (m_k != 0 && m_k == m_D && m_rf) m_resp = m_pend;
    end
  end

  task automatic wait_done(output int n, output logic rv_seen);
    n = 0;
    rv_seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      rv_seen = rv_seen | bus.resp_valid;
    end while (!bus.done && n < 40);
  endtask

  task automatic do_req(input logic wb, input logic rf, input logic [3:0] wa, input logic [2:0] wd,
                        input logic [3:0] ra, input int exp_lat, input logic [2:0] exp_data,
                        input string nm);
    int n;
    logic rv_seen;
    chk({nm, "_ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_wb = wb; bus.req_refill = rf;
    bus.wb_addr = wa; bus.wb_data = wd; bus.refill_addr = ra;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    wait_done(n, rv_seen);
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_rv"}, rv_seen, rf);
    if (rf) chk({nm, "_data"}, bus.resp_data, exp_data);
    @(posedge clk); #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    logic rv_seen, seen;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_wb = 1'b0; bus.req_refill = 1'b0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.refill_addr = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rv", bus.resp_valid, 0);
    chk("rst_data", bus.resp_data, 0);

    do_req(1'b0, 1'b1, 4'd0, 3'd0, 4'd9, 3, 3'b001, "rf9");
    do_req(1'b1, 1'b0, 4'd5, 3'b110, 4'd0, 3, 3'b000, "wb5");
    do_req(1'b0, 1'b1, 4'd0, 3'd0, 4'd5, 3, 3'b110, "rf5");
    do_req(1'b1, 1'b1, 4'd2, 3'b111, 4'd2, 5, 3'b111, "both2");

    // Request held high across busy; fields change right after the first accept.
    bus.req_valid = 1'b1; bus.req_wb = 1'b0; bus.req_refill = 1'b1; bus.refill_addr = 4'd15;
    @(posedge clk); #2;
    bus.refill_addr = 4'd3;
    wait_done(n, rv_seen);
    chk("held_a_lat", n, 3);
    chk("held_a_data", bus.resp_data, 3'b111);
    @(negedge clk);
    chk("held_ready_back", bus.req_ready, 1);
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    wait_done(n, rv_seen);
    chk("held_b_lat", n, 3);
    chk("held_b_data", bus.resp_data, 3'b011);
    @(posedge clk); #2;

    // Reset during the first write-back cycle discards the write.
    bus.req_valid = 1'b1; bus.req_wb = 1'b1; bus.req_refill = 1'b0;
    bus.wb_addr = 4'd7; bus.wb_data = 3'b000;
    @(posedge clk); #2;
    bus.req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", bus.req_ready, 1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus.done | bus.resp_valid;
    end
    chk("rstmid_no_pulse", seen, 0);
    @(posedge clk); #2;
    do_req(1'b0, 1'b1, 4'd0, 3'd0, 4'd7, 3, 3'b111, "rf7");

    do_req(1'b0, 1'b0, 4'd0, 3'd0, 4'd0, 1, 3'b000, "null");
    do_req(1'b1, 1'b1, 4'd9, 3'b010, 4'd9, 5, 3'b010, "both9");

`ifdef MEM_REFILL_STATS_EN
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("stat_rf_clr", stat_refills, 0);
    chk("stat_wb_clr", stat_writebacks, 0);
    for (int i = 0; i < 256; i++) do_req(1'b0, 1'b1, 4'd0, 3'd0, 4'd0, 3, 3'b000, "stat");
    chk("stat_rf_sat", stat_refills, 255);
    chk("stat_wb_zero", stat_writebacks, 0);
    do_req(1'b1, 1'b0, 4'd1, 3'b101, 4'd0, 3, 3'b000, "stat_wb");
    chk("stat_wb_one", stat_writebacks, 1);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
